// File: rtl/multi_pipe_nbit.sv
// Four-stage pipelined WIDTH x WIDTH multiplier, signed or unsigned per operation,
// with a whole-pipe stall on output backpressure and a single-cycle flush.
module multi_pipe_nbit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mul_en_in,
  output logic                 mul_rdy_in,
  input  logic                 mul_sign,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_flush,
  output logic                 mul_en_out,
  input  logic                 mul_rdy_out,
  output logic [2*WIDTH-1:0]   mul_out
);

  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic             s1_v_q, s1_v_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_v_q, s2_v_d;
  logic [PW-1:0]    s2_pp_lo_q, s2_pp_lo_d;
  logic [PW-1:0]    s2_pp_hi_q, s2_pp_hi_d;
  logic             s3_v_q, s3_v_d;
  logic [PW-1:0]    s3_sum_q, s3_sum_d;
  logic             s4_v_q, s4_v_d;
  logic [PW-1:0]    s4_out_q, s4_out_d;

  logic             stall;
  logic             accept;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [PW-1:0]    a_w;
  logic [PW-1:0]    b_lo_w;
  logic [PW-1:0]    b_hi_w;
  logic [PW-1:0]    pp_lo;
  logic [PW-1:0]    pp_hi;
  logic [PW-1:0]    sum;

  assign stall      = s4_v_q & ~mul_rdy_out;
  assign mul_rdy_in = rst_n & ~(stall | mul_flush);
  assign accept     = mul_en_in & mul_rdy_in;

  // Operands widened by one bit so signed and unsigned share one datapath; products
  // are taken modulo 2^PW, which is exact for both modes.
  assign a_ext  = {s1_sign_q & s1_a_q[WIDTH-1], s1_a_q};
  assign b_ext  = {s1_sign_q & s1_b_q[WIDTH-1], s1_b_q};
  assign a_w    = {{(PW-WIDTH-1){a_ext[WIDTH]}}, a_ext};
  assign b_lo_w = {{(PW-HW){1'b0}}, b_ext[HW-1:0]};
  assign b_hi_w = {{(PW-HW-1){b_ext[WIDTH]}}, b_ext[WIDTH:HW]};
  assign pp_lo  = a_w * b_lo_w;
  assign pp_hi  = a_w * b_hi_w;
  assign sum    = s2_pp_lo_q + (s2_pp_hi_q << HW);

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_sign_d  = s1_sign_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_v_d     = s2_v_q;
    s2_pp_lo_d = s2_pp_lo_q;
    s2_pp_hi_d = s2_pp_hi_q;
    s3_v_d     = s3_v_q;
    s3_sum_d   = s3_sum_q;
    s4_v_d     = s4_v_q;
    s4_out_d   = s4_out_q;
    if (mul_flush) begin
      s1_v_d     = 1'b0;
      s1_sign_d  = 1'b0;
      s1_a_d     = '0;
      s1_b_d     = '0;
      s2_v_d     = 1'b0;
      s2_pp_lo_d = '0;
      s2_pp_hi_d = '0;
      s3_v_d     = 1'b0;
      s3_sum_d   = '0;
      s4_v_d     = 1'b0;
      s4_out_d   = '0;
    end else if (!stall) begin
      // Empty slots carry zero data so mul_out is zero whenever it is not valid.
      s1_v_d     = accept;
      s1_sign_d  = accept & mul_sign;
      s1_a_d     = accept ? mul_a : '0;
      s1_b_d     = accept ? mul_b : '0;
      s2_v_d     = s1_v_q;
      s2_pp_lo_d = s1_v_q ? pp_lo : '0;
      s2_pp_hi_d = s1_v_q ? pp_hi : '0;
      s3_v_d     = s2_v_q;
      s3_sum_d   = s2_v_q ? sum : '0;
      s4_v_d     = s3_v_q;
      s4_out_d   = s3_v_q ? s3_sum_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_pp_lo_q <= '0;
      s2_pp_hi_q <= '0;
      s3_v_q     <= 1'b0;
      s3_sum_q   <= '0;
      s4_v_q     <= 1'b0;
      s4_out_q   <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sign_q  <= s1_sign_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_v_q     <= s2_v_d;
      s2_pp_lo_q <= s2_pp_lo_d;
      s2_pp_hi_q <= s2_pp_hi_d;
      s3_v_q     <= s3_v_d;
      s3_sum_q   <= s3_sum_d;
      s4_v_q     <= s4_v_d;
      s4_out_q   <= s4_out_d;
    end
  end

  assign mul_en_out = s4_v_q;
  assign mul_out    = s4_out_q;

endmodule
